// File: rtl/freq_meter_pkg.sv
// ============================================================
// freq_meter_pkg : shared types and helpers for the frequency meter
// Rev 1.0
// ============================================================
`default_nettype none

package freq_meter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    EVAL   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] RANGE_1S    = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_10MS  = 2'd2;

  // Gate length in clk cycles for a range index (clk_hz must be divisible by 100)
  function automatic int unsigned gate_len(input int unsigned clk_hz, input logic [1:0] r);
    case (r)
      RANGE_1S:    return clk_hz;
      RANGE_100MS: return clk_hz / 10;
      default:     return clk_hz / 100;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_gate_timer.sv
// ============================================================
// freq_gate_timer : loadable down-counter with a zero flag
// Rev 1.0
// ============================================================
`default_nettype none

module freq_gate_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/freq_meter_ctrl.sv
// ============================================================
// freq_meter_ctrl : gate-time sequencer and auto-ranging controller
// Rev 1.0
// ============================================================
`default_nettype none

module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned HI_TH      = 99_999_999,
  parameter int unsigned LO_TH      = 1_000_000,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned RANGE_INIT = 0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Cont,
  input  logic             Auto,
  input  logic [CNT_W-1:0] Cnt_Val,
  input  logic             Cnt_Ovf,
  output logic             Cnt_Clr,
  output logic             Cnt_En,
  output logic [CNT_W-1:0] Result,
  output logic [1:0]       Range,
  output logic             Valid,
  output logic             Overrange,
  output logic             Busy
);

  localparam int unsigned      TW      = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] HI_VAL  = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0] LO_VAL  = CNT_W'(LO_TH);
  localparam logic [1:0]       R_INIT  = 2'(RANGE_INIT);
  localparam logic [TW-1:0]    SET_LD  = TW'(SETTLE_CYC - 1);

  state_t           state, state_next;
  logic [1:0]       range_q, range_next;
  logic [CNT_W-1:0] result_q, result_next;
  logic             ovr_q, ovr_next;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]    tmr_load_val;
  logic             saturated;
  logic [CNT_W-1:0] sat_val;

  freq_gate_timer #(.W(TW)) u_timer (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      range_q  <= R_INIT;
      result_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_next;
      range_q  <= range_next;
      result_q <= result_next;
      ovr_q    <= ovr_next;
    end
  end

  always_comb begin
    state_next   = state;
    range_next   = range_q;
    result_next  = result_q;
    ovr_next     = ovr_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    saturated    = Cnt_Ovf || (Cnt_Val > HI_VAL);
    sat_val      = Cnt_Ovf ? '1 : Cnt_Val;

    case (state)
      IDLE: begin
        if (Start) state_next = CLEAR;
      end
      CLEAR: begin
        tmr_load     = 1'b1;
        tmr_load_val = TW'(gate_len(CLK_HZ, range_q) - 1);
        state_next   = GATE;
      end
      GATE: begin
        // The timer is reused to time the settle window once the gate closes
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = SET_LD;
          state_next   = SETTLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) state_next = EVAL;
        else          tmr_dec    = 1'b1;
      end
      EVAL: begin
        if (Auto && saturated && (range_q < RANGE_10MS)) begin
          range_next = range_q + 2'd1;
          state_next = CLEAR;
        end else if (saturated) begin
          result_next = sat_val;
          ovr_next    = 1'b1;
          state_next  = DONE;
        end else if (Auto && (Cnt_Val < LO_VAL) && (range_q > RANGE_1S)) begin
          range_next = range_q - 2'd1;
          state_next = CLEAR;
        end else begin
          result_next = Cnt_Val;
          ovr_next    = 1'b0;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = Cont ? CLEAR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Cnt_Clr   = (state == CLEAR);
  assign Cnt_En    = (state == GATE);
  assign Valid     = (state == DONE);
  assign Busy      = (state != IDLE);
  assign Result    = result_q;
  assign Range     = range_q;
  assign Overrange = ovr_q;

endmodule

`default_nettype wire
